// File: rtl/pcla_pkg.sv
// rtl/pcla_pkg.sv - shared types, defaults and group lookahead helper for the pipelined CLA
package pcla_pkg;

   localparam int PCLA_WIDTH = 16;
   localparam int PCLA_GROUP = 4;

   typedef struct packed {
      logic p;
      logic g;
   } pg_t;

   // Group propagate/generate over the low n bits of p/g (n = 1..8).
   function automatic pg_t group_pg(input logic [7:0] p, input logic [7:0] g, input int n);
      pg_t r;
      r.p = 1'b1;
      r.g = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i < n) begin
            r.g = g[i] | (p[i] & r.g);
            r.p = r.p & p[i];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - combinational GROUP-bit carry-lookahead slice with group P/G
module cla_group
   import pcla_pkg::*;
#(
   parameter int GROUP = PCLA_GROUP
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             cin,
   output logic [GROUP-1:0] sum,
   output logic             cout,
   output pg_t              pg
);

   logic [GROUP-1:0] p;
   logic [GROUP-1:0] g;
   logic [GROUP-1:0] c;

   always_comb begin
      p    = a ^ b;
      g    = a & b;
      c    = '0;
      c[0] = cin;
      for (int i = 1; i < GROUP; i++) begin
         c[i] = g[i-1] | (p[i-1] & c[i-1]);
      end
      sum  = p ^ c;
      pg   = group_pg(8'(p), 8'(g), GROUP);
      cout = pg.g | (pg.p & cin);
   end

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined CLA adder, one GROUP-bit group per stage, global stall
// Define PCLA_FLAGS_EN to add registered out_ovf/out_zero flags.
module pipelined_cla_adder
   import pcla_pkg::*;
#(
   parameter int WIDTH = PCLA_WIDTH,
   parameter int GROUP = PCLA_GROUP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
`ifdef PCLA_FLAGS_EN
  ,output logic             out_ovf,
   output logic             out_zero
`endif
);

   localparam int NG = WIDTH / GROUP;

   if ((WIDTH % GROUP) != 0 || GROUP < 1 || GROUP > 8) begin : g_param_check
      $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP and GROUP must be 1..8");
   end

   logic advance;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < NG; k++) begin : g_stage
      logic [GROUP-1:0]         ga;
      logic [GROUP-1:0]         gb;
      logic [GROUP-1:0]         gs;
      logic                     gcin;
      logic                     gcout;
      logic                     vin;
      pg_t                      pg_unused;
      logic [(k+1)*GROUP-1:0]   s_n;
      logic [(k+1)*GROUP-1:0]   s_q;
      logic                     v_q;
      logic                     c_q;

      if (k == 0) begin : g_src
         assign ga   = in_a[GROUP-1:0];
         assign gb   = in_b[GROUP-1:0];
         assign gcin = in_cin;
         assign vin  = in_valid;
         assign s_n  = gs;
      end else begin : g_src
         assign ga   = g_stage[k-1].g_up.a_up[GROUP-1:0];
         assign gb   = g_stage[k-1].g_up.b_up[GROUP-1:0];
         assign gcin = g_stage[k-1].c_q;
         assign vin  = g_stage[k-1].v_q;
         assign s_n  = {gs, g_stage[k-1].s_q};
      end

      cla_group #(.GROUP(GROUP)) u_grp (
         .a    (ga),
         .b    (gb),
         .cin  (gcin),
         .sum  (gs),
         .cout (gcout),
         .pg   (pg_unused)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (advance) begin
            v_q <= vin;
            c_q <= gcout;
            s_q <= s_n;
         end
      end

      // Operand bits still owed to later groups ride along with the partial sum.
      if (k < NG-1) begin : g_up
         localparam int UW = WIDTH - (k+1)*GROUP;
         logic [UW-1:0] a_up;
         logic [UW-1:0] b_up;
         logic [UW-1:0] a_nx;
         logic [UW-1:0] b_nx;

         if (k == 0) begin : g_nx
            assign a_nx = in_a[WIDTH-1:GROUP];
            assign b_nx = in_b[WIDTH-1:GROUP];
         end else begin : g_nx
            assign a_nx = g_stage[k-1].g_up.a_up[UW+GROUP-1:GROUP];
            assign b_nx = g_stage[k-1].g_up.b_up[UW+GROUP-1:GROUP];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_up <= '0;
               b_up <= '0;
            end else if (advance) begin
               a_up <= a_nx;
               b_up <= b_nx;
            end
         end
      end

`ifdef PCLA_FLAGS_EN
      if (k == NG-1) begin : g_flags
         logic ovf_q;
         logic zero_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (advance) begin
               ovf_q  <= (ga[GROUP-1] == gb[GROUP-1]) && (gs[GROUP-1] != ga[GROUP-1]);
               zero_q <= (s_n == '0);
            end
         end
      end
`endif
   end

   assign out_valid = g_stage[NG-1].v_q;
   assign out_sum   = g_stage[NG-1].s_q;
   assign out_cout  = g_stage[NG-1].c_q;

`ifdef PCLA_FLAGS_EN
   assign out_ovf   = g_stage[NG-1].g_flags.ovf_q;
   assign out_zero  = g_stage[NG-1].g_flags.zero_q;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - directed self-checking bench for pipelined_cla_adder (8-bit and 16-bit)
module tb_pipelined_cla_adder;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   logic        iv8, ir8, ov8, or8, cin8, cout8;
   logic [7:0]  a8, b8, sum8;
   logic        iv16, ir16, ov16, or16, cin16, cout16;
   logic [15:0] a16, b16, sum16;
`ifdef PCLA_FLAGS_EN
   logic        ovf8, zero8, ovf16, zero16;
`endif

   int passed = 0;
   int total  = 0;

   logic [7:0]  va8 [5] = '{8'h35, 8'hFF, 8'hF0, 8'h7F, 8'h80};
   logic [7:0]  vb8 [5] = '{8'hC1, 8'hFF, 8'h0F, 8'h01, 8'h80};
   logic        vc8 [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic [7:0]  es8 [5] = '{8'hF6, 8'hFE, 8'h00, 8'h80, 8'h00};
   logic        ec8 [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic        eo8 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   logic        ez8 [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   logic [15:0] sa16 [5] = '{16'h1000, 16'h00FF, 16'hFFFF, 16'h1234, 16'h8000};
   logic [15:0] sb16 [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h4321, 16'h8000};
   logic        sc16 [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [16:0] se16 [5] = '{17'h01001, 17'h00100, 17'h10001, 17'h05555, 17'h10001};
   logic [16:0] got [$];

   pipelined_cla_adder #(.WIDTH(8), .GROUP(4)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv8),
      .in_ready  (ir8),
      .in_a      (a8),
      .in_b      (b8),
      .in_cin    (cin8),
      .out_valid (ov8),
      .out_ready (or8),
      .out_sum   (sum8),
      .out_cout  (cout8)
`ifdef PCLA_FLAGS_EN
     ,.out_ovf   (ovf8),
      .out_zero  (zero8)
`endif
   );

   pipelined_cla_adder dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv16),
      .in_ready  (ir16),
      .in_a      (a16),
      .in_b      (b16),
      .in_cin    (cin16),
      .out_valid (ov16),
      .out_ready (or16),
      .out_sum   (sum16),
      .out_cout  (cout16)
`ifdef PCLA_FLAGS_EN
     ,.out_ovf   (ovf16),
      .out_zero  (zero16)
`endif
   );

   task automatic test_reset;
      rst_n = 1'b0;
      iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; or8 = 1'b1;
      iv16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; or16 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (ov8 !== 1'b0) $display("FAIL reset_valid8: got %b want 0", ov8); else passed++;
      total++; if (sum8 !== 8'h00) $display("FAIL reset_sum8: got %h want 00", sum8); else passed++;
      total++; if (cout8 !== 1'b0) $display("FAIL reset_cout8: got %b want 0", cout8); else passed++;
      total++; if (ir8 !== 1'b1) $display("FAIL reset_ready8: got %b want 1", ir8); else passed++;
      total++; if (ov16 !== 1'b0) $display("FAIL reset_valid16: got %b want 0", ov16); else passed++;
      total++; if (sum16 !== 16'h0000) $display("FAIL reset_sum16: got %h want 0000", sum16); else passed++;
      total++; if (ir16 !== 1'b1) $display("FAIL reset_ready16: got %b want 1", ir16); else passed++;
`ifdef PCLA_FLAGS_EN
      total++; if (ovf8 !== 1'b0) $display("FAIL reset_ovf8: got %b want 0", ovf8); else passed++;
      total++; if (zero8 !== 1'b0) $display("FAIL reset_zero8: got %b want 0", zero8); else passed++;
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_single8;
      for (int i = 0; i < 5; i++) begin
         a8 = va8[i]; b8 = vb8[i]; cin8 = vc8[i]; iv8 = 1'b1;
         @(posedge clk); #1;
         iv8 = 1'b0;
         @(negedge clk);
         total++; if (ov8 !== 1'b0) $display("FAIL single8_early[%0d]: valid got %b want 0", i, ov8); else passed++;
         @(negedge clk);
         total++; if (ov8 !== 1'b1) $display("FAIL single8_valid[%0d]: got %b want 1", i, ov8); else passed++;
         total++; if (sum8 !== es8[i]) $display("FAIL single8_sum[%0d]: got %h want %h", i, sum8, es8[i]); else passed++;
         total++; if (cout8 !== ec8[i]) $display("FAIL single8_cout[%0d]: got %b want %b", i, cout8, ec8[i]); else passed++;
`ifdef PCLA_FLAGS_EN
         total++; if (ovf8 !== eo8[i]) $display("FAIL single8_ovf[%0d]: got %b want %b", i, ovf8, eo8[i]); else passed++;
         total++; if (zero8 !== ez8[i]) $display("FAIL single8_zero[%0d]: got %b want %b", i, zero8, ez8[i]); else passed++;
`endif
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] ta [3];
      logic [15:0] tb [3];
      logic [15:0] te [3];
      ta = '{16'h0011, 16'h0003, 16'hAAAA};
      tb = '{16'h0001, 16'h0003, 16'h0000};
      te = '{16'h0012, 16'h0006, 16'hAAAA};
      for (int i = 0; i < 3; i++) begin
         a16 = ta[i]; b16 = tb[i]; cin16 = 1'b0; iv16 = 1'b1;
         @(posedge clk); #1;
      end
      iv16 = 1'b0;
      @(negedge clk);
      total++; if (ov16 !== 1'b0) $display("FAIL b2b_latency: valid got %b want 0", ov16); else passed++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++; if (ov16 !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", i, ov16); else passed++;
         total++; if (sum16 !== te[i]) $display("FAIL b2b_sum[%0d]: got %h want %h", i, sum16, te[i]); else passed++;
         total++; if (cout16 !== 1'b0) $display("FAIL b2b_cout[%0d]: got %b want 0", i, cout16); else passed++;
      end
      @(negedge clk);
      total++; if (ov16 !== 1'b0) $display("FAIL b2b_tail: valid got %b want 0", ov16); else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_stall;
      got.delete();
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               int guard;
               guard = 0;
               a16 = sa16[i]; b16 = sb16[i]; cin16 = sc16[i]; iv16 = 1'b1;
               @(negedge clk);
               while (ir16 !== 1'b1 && guard < 50) begin
                  @(negedge clk);
                  guard++;
               end
               total++; if (guard >= 50) $display("FAIL stall_accept_timeout[%0d]: waited %0d cycles, limit 50", i, guard); else passed++;
               @(posedge clk); #1;
            end
            iv16 = 1'b0;
         end
         begin
            int cyc;
            cyc = 0;
            while (got.size() < 5 && cyc < 80) begin
               @(negedge clk);
               cyc++;
               if (ov16 === 1'b1 && or16 === 1'b1) got.push_back({cout16, sum16});
            end
         end
         begin
            logic [15:0] held;
            repeat (4) @(posedge clk);
            #1 or16 = 1'b0;
            @(negedge clk);
            held = sum16;
            total++; if (ov16 !== 1'b1) $display("FAIL stall_valid0: got %b want 1", ov16); else passed++;
            total++; if (ir16 !== 1'b0) $display("FAIL stall_ready0: got %b want 0", ir16); else passed++;
            total++; if (held !== 16'h1001) $display("FAIL stall_head: got %h want 1001", held); else passed++;
            for (int j = 1; j < 3; j++) begin
               @(negedge clk);
               total++; if (sum16 !== held) $display("FAIL stall_hold[%0d]: got %h want %h", j, sum16, held); else passed++;
               total++; if (ir16 !== 1'b0) $display("FAIL stall_ready[%0d]: got %b want 0", j, ir16); else passed++;
               total++; if (ov16 !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", j, ov16); else passed++;
            end
            @(posedge clk); #1;
            or16 = 1'b1;
         end
      join
      total++; if (got.size() != 5) $display("FAIL stall_count: got %0d results want 5", got.size()); else passed++;
      for (int i = 0; i < 5; i++) begin
         if (i < got.size()) begin
            total++; if (got[i] !== se16[i]) $display("FAIL stall_result[%0d]: got %h want %h", i, got[i], se16[i]); else passed++;
         end
      end
      begin
         int extra;
         extra = 0;
         repeat (4) begin
            @(negedge clk);
            if (ov16 === 1'b1) extra++;
         end
         total++; if (extra != 0) $display("FAIL stall_duplicate: got %0d extra valid cycles want 0", extra); else passed++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midflight;
      int stale;
      for (int i = 0; i < 3; i++) begin
         a16 = 16'h0101 * 16'(i + 1); b16 = 16'h0202; cin16 = 1'b0; iv16 = 1'b1;
         @(posedge clk); #1;
      end
      iv16 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total++; if (ov16 !== 1'b1) $display("FAIL rst_pre_valid: got %b want 1", ov16); else passed++;
      total++; if (sum16 !== 16'h0303) $display("FAIL rst_pre_sum: got %h want 0303", sum16); else passed++;
      rst_n = 1'b0;
      #1;
      total++; if (ov16 !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", ov16); else passed++;
      total++; if (sum16 !== 16'h0000) $display("FAIL rst_async_sum: got %h want 0000", sum16); else passed++;
      total++; if (cout16 !== 1'b0) $display("FAIL rst_async_cout: got %b want 0", cout16); else passed++;
      total++; if (ir16 !== 1'b1) $display("FAIL rst_async_ready: got %b want 1", ir16); else passed++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      stale = 0;
      repeat (8) begin
         @(negedge clk);
         if (ov16 === 1'b1) stale++;
      end
      total++; if (stale != 0) $display("FAIL rst_stale: got %0d valid cycles want 0", stale); else passed++;
      total++; if (ir16 !== 1'b1) $display("FAIL rst_post_ready: got %b want 1", ir16); else passed++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded 200000 time units");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single8();
      test_back_to_back();
      test_stall();
      test_reset_midflight();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
